// File: rtl/encoder_4to2_irq.sv
// Sequential 4-to-2 priority encoder with request capture, hold-until-ACK and post-ACK gap.
// Define ENC_ROUND_ROBIN_EN to use round-robin arbitration in place of fixed D3-first priority.
module encoder_4to2_irq #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned LEVEL_MODE = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic       D3,
    input  logic       D2,
    input  logic       D1,
    input  logic       D0,
    input  logic       ACK,
    output logic       A1,
    output logic       A0,
    output logic       V,
    output logic [3:0] PEND
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_GAP     = 2'd2;

    localparam logic [2:0] GAP_LAST = (GAP_CYCLES == 0) ? 3'd0 : 3'(GAP_CYCLES - 1);

    logic [3:0] d_vec;
    logic [3:0] d_prev;
    logic [3:0] pend;
    logic [3:0] capture;
    logic [3:0] clr_mask;
    logic [3:0] pend_nxt;
    logic [1:0] state;
    logic [1:0] a_q;
    logic [1:0] pick;
    logic [2:0] gap_cnt;
    logic       v_q;
    logic       ack_fire;

    assign d_vec = {D3, D2, D1, D0};

    always_comb begin
        capture = '0;
        if (EN) begin
            if (LEVEL_MODE != 0) capture = d_vec;
            else                 capture = d_vec & ~d_prev;
        end
    end

    assign ack_fire = (state == ST_PRESENT) && ACK;

    // Set is OR-ed after the clear so a capture on the bit being ACKed survives.
    always_comb begin
        clr_mask = '0;
        if (ack_fire) clr_mask[a_q] = 1'b1;
        pend_nxt = (pend & ~clr_mask) | capture;
    end

`ifdef ENC_ROUND_ROBIN_EN
    logic [1:0] last_served;
    logic [1:0] cand;
    logic       found;

    // Search downward from last_served-1, wrapping; k=4 lands back on last_served itself.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_served - 2'(k);
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_served <= '0;
        end else if (state == ST_IDLE && EN && pend != '0) begin
            last_served <= pick;
        end
    end
`else
    always_comb begin
        pick = '0;
        if      (pend[3]) pick = 2'd3;
        else if (pend[2]) pick = 2'd2;
        else if (pend[1]) pick = 2'd1;
        else              pick = 2'd0;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            d_prev <= '0;
            pend   <= '0;
        end else begin
            d_prev <= d_vec;
            pend   <= pend_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            v_q     <= 1'b0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (EN && pend != '0) begin
                        a_q   <= pick;
                        v_q   <= 1'b1;
                        state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ACK) begin
                        v_q     <= 1'b0;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= ST_IDLE;
                    else                     gap_cnt <= gap_cnt + 3'd1;
                end
                default: begin
                    state <= ST_IDLE;
                    v_q   <= 1'b0;
                end
            endcase
        end
    end

    assign A1   = a_q[1];
    assign A0   = a_q[0];
    assign V    = v_q;
    assign PEND = pend;

endmodule

// File: tb/tb_encoder_4to2_irq.sv
// Directed bench for encoder_4to2_irq (GAP_CYCLES=1, LEVEL_MODE=0); honours ENC_ROUND_ROBIN_EN.
module tb_encoder_4to2_irq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d3, d2, d1, d0;
    logic       ack;
    logic       a1, a0, v;
    logic [3:0] pend;

    int unsigned total;
    int unsigned bad;

    encoder_4to2_irq #(
        .GAP_CYCLES(1),
        .LEVEL_MODE(0)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .EN   (en),
        .D3   (d3),
        .D2   (d2),
        .D1   (d1),
        .D0   (d0),
        .ACK  (ack),
        .A1   (a1),
        .A0   (a0),
        .V    (v),
        .PEND (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [3:0] val);
        {d3, d2, d1, d0} = val;
    endtask

    function automatic logic [3:0] a_out();
        return {2'b00, a1, a0};
    endfunction

    logic [1:0] order [4];

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        ack   = 1'b0;
        set_d(4'b0000);
        order[0] = 2'd3;
        order[1] = 2'd2;
        order[2] = 2'd1;
        order[3] = 2'd0;

        // Reset and single request
        tick();
        tick();
        check("rst_v",    {3'b0, v}, 4'b0000);
        check("rst_a",    a_out(),   4'b0000);
        check("rst_pend", pend,      4'b0000);
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        set_d(4'b0010);
        tick();
        check("single_pend_cap", pend,      4'b0010);
        check("single_v_cap",    {3'b0, v}, 4'b0000);
        set_d(4'b0000);
        tick();
        check("single_v",  {3'b0, v}, 4'b0001);
        check("single_a",  a_out(),   4'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("single_ack_v",    {3'b0, v}, 4'b0000);
        check("single_ack_pend", pend,      4'b0000);
        tick();
        tick();

        // Priority: D2 and D0 together
        set_d(4'b0101);
        tick();
        check("prio_pend", pend, 4'b0101);
        set_d(4'b0000);
        tick();
        check("prio_first_a", a_out(),   4'b0010);
        check("prio_first_v", {3'b0, v}, 4'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("prio_ack_pend", pend,      4'b0001);
        check("prio_ack_v",    {3'b0, v}, 4'b0000);
        tick();
        check("prio_gap_v", {3'b0, v}, 4'b0000);
        tick();
        check("prio_second_a", a_out(),   4'b0000);
        check("prio_second_v", {3'b0, v}, 4'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("prio_done_pend", pend, 4'b0000);
        tick();
        tick();

        // Stability: D3 arrives while D0 is presented
        set_d(4'b0001);
        tick();
        set_d(4'b0000);
        tick();
        check("stab_a0", a_out(), 4'b0000);
        set_d(4'b1000);
        tick();
        check("stab_pend",  pend,      4'b1001);
        check("stab_hold",  a_out(),   4'b0000);
        check("stab_hold_v", {3'b0, v}, 4'b0001);
        set_d(4'b0000);
        tick();
        check("stab_hold2", a_out(), 4'b0000);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("stab_ack_pend", pend, 4'b1000);
        tick();
        tick();
        check("stab_next_a", a_out(),   4'b0011);
        check("stab_next_v", {3'b0, v}, 4'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        tick();

        // EN gating
        en = 1'b0;
        set_d(4'b0100);
        tick();
        check("en_off_pend", pend,      4'b0000);
        check("en_off_v",    {3'b0, v}, 4'b0000);
        tick();
        en = 1'b1;
        tick();
        check("en_on_pend", pend,      4'b0000);
        tick();
        check("en_on_v",    {3'b0, v}, 4'b0000);
        set_d(4'b0000);
        tick();

        // Capture colliding with ACK of the same index
        set_d(4'b0010);
        tick();
        set_d(4'b0000);
        tick();
        check("coll_a", a_out(), 4'b0001);
        set_d(4'b0010);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        set_d(4'b0000);
        check("coll_pend", pend,      4'b0010);
        check("coll_v",    {3'b0, v}, 4'b0000);
        tick();
        tick();
        check("coll_re_a", a_out(),   4'b0001);
        check("coll_re_v", {3'b0, v}, 4'b0001);

        // Asynchronous reset mid-presentation, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_v",    {3'b0, v}, 4'b0000);
        check("arst_a",    a_out(),   4'b0000);
        check("arst_pend", pend,      4'b0000);
        tick();
        rst_n = 1'b1;
        tick();

        // All four held pending
        set_d(4'b1111);
        tick();
        check("all_pend", pend, 4'b1111);
        tick();
        check("all_first_a", a_out(), 4'b0011);
`ifndef ENC_ROUND_ROBIN_EN
        // Fixed priority: a fresh D3 edge is served again before D2
        ack = 1'b1;
        set_d(4'b0111);
        tick();
        ack = 1'b0;
        check("fix_ack_pend", pend, 4'b0111);
        set_d(4'b1111);
        tick();
        check("fix_recap_pend", pend, 4'b1111);
        tick();
`endif
        for (int unsigned i = 0; i < 4; i++) begin
            check($sformatf("order_a%0d", i), a_out(), {2'b00, order[i]});
            check($sformatf("order_v%0d", i), {3'b0, v}, 4'b0001);
            ack = 1'b1;
            tick();
            ack = 1'b0;
            tick();
            tick();
        end
        check("order_done_pend", pend,      4'b0000);
        check("order_done_v",    {3'b0, v}, 4'b0000);
        set_d(4'b0111);
        tick();
        set_d(4'b1111);
        tick();
        tick();
        check("rereq_a", a_out(),   4'b0011);
        check("rereq_v", {3'b0, v}, 4'b0001);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        set_d(4'b0000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
